onewire_slave: RTL and testbench

//  1-Wire responder (slave): the far end of onewire_master on the same bus. It detects the

---
 rtl/onewire_slave.sv | 193 +++++++++++++++++++
 tb/tb_onewire_slave.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/onewire_slave.sv
// 1-Wire responder: detects bus resets, answers with presence, receives write slots, returns a queued byte in read slots.
// Latency: bus-to-decision 2 cycles (synchroniser); rx_vld pulses on the cycle the 8th slot returns to IDLE.
// Backpressure: tx_rdy_o is high only in IDLE at a byte boundary with no tx byte pending; rx has no backpressure.
module onewire_slave #(
    parameter int RST_MIN = 4000,
    parameter int PD_WAIT = 300,
    parameter int PD_LEN  = 1200,
    parameter int SAMPLE  = 300,
    parameter int TX_HOLD = 300,
    parameter int CNT_W   = 13
) (
    input  logic       clk_10,
    input  logic       arst_n,
    input  logic       ow_in_i,
    output logic       ow_pull_low_o,
    output logic [7:0] rx_data_o,
    output logic       rx_vld_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_vld_i,
    output logic       tx_rdy_o,
    output logic       rst_det_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_LOW,
        ST_PD_DLY,
        ST_PD_DRV,
        ST_PD_END,
        ST_SLOT,
        ST_SLOT_END
    } state_t;

    localparam logic [CNT_W-1:0] RST_MIN_C  = CNT_W'(RST_MIN);
    localparam logic [CNT_W-1:0] PD_WAIT_M1 = CNT_W'(PD_WAIT - 1);
    localparam logic [CNT_W-1:0] PD_LEN_M1  = CNT_W'(PD_LEN - 1);
    localparam logic [CNT_W-1:0] SAMPLE_M1  = CNT_W'(SAMPLE - 1);
    localparam logic [CNT_W-1:0] TX_HOLD_M1 = CNT_W'(TX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q;
    logic             ow_m_q, ow_s_q, ow_p_q;
    logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d;
    logic [CNT_W-1:0] timer_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       rx_sh_q, tx_sh_q;
    logic             tx_pend_q;
    logic             pull_q, rx_vld_q, rst_det_q;
    logic [7:0]       rx_data_q;
    logic             rst_hit, ow_fall, accept, eff_pend;
    logic [7:0]       eff_sh;

    assign ow_pull_low_o = pull_q;
    assign rx_data_o     = rx_data_q;
    assign rx_vld_o      = rx_vld_q;
    assign rst_det_o     = rst_det_q;
    assign tx_rdy_o      = ~tx_pend_q & (state_q == ST_IDLE) & (bit_cnt_q == 3'd0);

    assign ow_fall  = ow_p_q & ~ow_s_q;
    assign accept   = tx_vld_i & tx_rdy_o;
    // A byte accepted in the same cycle a slot starts must already drive that slot.
    assign eff_pend = tx_pend_q | accept;
    assign eff_sh   = accept ? tx_data_i : tx_sh_q;

    // Two-flop synchroniser plus one delayed copy for edge detection; idle bus is high.
    always_ff @(posedge clk_10 or negedge arst_n) begin
        if (!arst_n) begin
            ow_m_q <= 1'b1;
            ow_s_q <= 1'b1;
            ow_p_q <= 1'b1;
        end else begin
            ow_m_q <= ow_in_i;
            ow_s_q <= ow_m_q;
            ow_p_q <= ow_s_q;
        end
    end

    // Low timer: counts bus-low time not caused by us, saturating; the step onto RST_MIN qualifies a reset.
    always_comb begin
        lo_cnt_d = lo_cnt_q;
        rst_hit  = 1'b0;
        if (ow_s_q) begin
            lo_cnt_d = '0;
        end else if (!pull_q && (lo_cnt_q != RST_MIN_C)) begin
            lo_cnt_d = lo_cnt_q + CNT_ONE;
            rst_hit  = (lo_cnt_d == RST_MIN_C);
        end
    end

    // Main FSM with registered outputs; a qualified bus reset overrides every state.
    always_ff @(posedge clk_10 or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= ST_IDLE;
            lo_cnt_q  <= '0;
            timer_q   <= '0;
            bit_cnt_q <= 3'd0;
            rx_sh_q   <= 8'h00;
            tx_sh_q   <= 8'h00;
            tx_pend_q <= 1'b0;
            pull_q    <= 1'b0;
            rx_data_q <= 8'h00;
            rx_vld_q  <= 1'b0;
            rst_det_q <= 1'b0;
        end else begin
            lo_cnt_q  <= lo_cnt_d;
            rx_vld_q  <= 1'b0;
            rst_det_q <= 1'b0;
            if (rst_hit) begin
                rst_det_q <= 1'b1;
                state_q   <= ST_RST_LOW;
                pull_q    <= 1'b0;
                tx_pend_q <= 1'b0;
                bit_cnt_q <= 3'd0;
                timer_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept) begin
                            tx_sh_q   <= tx_data_i;
                            tx_pend_q <= 1'b1;
                        end
                        if (ow_fall) begin
                            state_q <= ST_SLOT;
                            timer_q <= '0;
                            pull_q  <= eff_pend & ~eff_sh[0];
                        end
                    end
                    ST_RST_LOW: begin
                        if (ow_s_q) begin
                            state_q <= ST_PD_DLY;
                            timer_q <= '0;
                        end
                    end
                    ST_PD_DLY: begin
                        if (timer_q == PD_WAIT_M1) begin
                            state_q <= ST_PD_DRV;
                            pull_q  <= 1'b1;
                            timer_q <= '0;
                        end else begin
                            timer_q <= timer_q + CNT_ONE;
                        end
                    end
                    ST_PD_DRV: begin
                        if (timer_q == PD_LEN_M1) begin
                            state_q <= ST_PD_END;
                            pull_q  <= 1'b0;
                        end else begin
                            timer_q <= timer_q + CNT_ONE;
                        end
                    end
                    ST_PD_END: begin
                        if (ow_s_q) state_q <= ST_IDLE;
                    end
                    ST_SLOT: begin
                        if (tx_pend_q) begin
                            // Release one cycle early so the pull spans exactly TX_HOLD cycles.
                            if (timer_q == TX_HOLD_M1) begin
                                pull_q  <= 1'b0;
                                tx_sh_q <= tx_sh_q >> 1;
                                state_q <= ST_SLOT_END;
                            end else begin
                                timer_q <= timer_q + CNT_ONE;
                            end
                        end else begin
                            if (timer_q == SAMPLE_M1) begin
                                rx_sh_q <= {ow_s_q, rx_sh_q[7:1]};
                                state_q <= ST_SLOT_END;
                            end else begin
                                timer_q <= timer_q + CNT_ONE;
                            end
                        end
                    end
                    ST_SLOT_END: begin
                        if (ow_s_q) begin
                            state_q   <= ST_IDLE;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (tx_pend_q) begin
                                    tx_pend_q <= 1'b0;
                                end else begin
                                    rx_data_q <= rx_sh_q;
                                    rx_vld_q  <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_onewire_slave.sv
`timescale 1ns/1ps
module tb_onewire_slave;

    logic       clk_10 = 1'b0;
    logic       arst_n;
    logic       m_low;
    logic       tx_vld;
    logic [7:0] tx_data;
    wire        ow_pull_low, rx_vld, tx_rdy, rst_det;
    wire [7:0]  rx_data;
    wire        ow_bus;

    always #50 clk_10 = ~clk_10;

    // Open-drain bus: low if either side pulls.
    assign ow_bus = ~(m_low | ow_pull_low);

    onewire_slave dut (
        .clk_10        (clk_10),
        .arst_n        (arst_n),
        .ow_in_i       (ow_bus),
        .ow_pull_low_o (ow_pull_low),
        .rx_data_o     (rx_data),
        .rx_vld_o      (rx_vld),
        .tx_data_i     (tx_data),
        .tx_vld_i      (tx_vld),
        .tx_rdy_o      (tx_rdy),
        .rst_det_o     (rst_det)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_rst    = 0;
    int         n_rx     = 0;
    logic [7:0] last_rx  = 8'h00;
    time        t_rst    = 0;
    time        t_prise  = 0;
    time        t_pfall  = 0;
    logic       pl_prev  = 1'b0;

    // Event monitor sampled on the falling edge.
    always @(negedge clk_10) begin
        if (rst_det === 1'b1) begin
            n_rst++;
            t_rst = $time;
        end
        if (rx_vld === 1'b1) begin
            n_rx++;
            last_rx = rx_data;
        end
        if (ow_pull_low === 1'b1 && !pl_prev) t_prise = $time;
        if (ow_pull_low !== 1'b1 && pl_prev) t_pfall = $time;
        pl_prev = (ow_pull_low === 1'b1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_10);
    endtask

    task automatic bus_low(input int low, input int total);
        m_low = 1'b1;
        wait_cyc(low);
        m_low = 1'b0;
        wait_cyc(total - low);
    endtask

    // Write-1: 6us low, write-0: 60us low, 70us slot.
    task automatic write_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) bus_low(b[i] ? 60 : 600, 700);
    endtask

    // Read slot: 6us low, sample at 15us, 70us slot.
    task automatic read_byte(output logic [7:0] b);
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m_low = 1'b1;
            wait_cyc(60);
            m_low = 1'b0;
            wait_cyc(90);
            b[i] = ow_bus;
            if (i == 3) chk("tx_rdy_busy", {31'd0, tx_rdy}, 32'd0);
            wait_cyc(550);
        end
    endtask

    task automatic offer_tx(input logic [7:0] d);
        int k = 0;
        while (tx_rdy !== 1'b1 && k < 100) begin
            wait_cyc(1);
            k++;
        end
        chk("tx_rdy_wait", {31'd0, tx_rdy}, 32'd1);
        tx_data = d;
        tx_vld  = 1'b1;
        wait_cyc(1);
        tx_vld  = 1'b0;
    endtask

    // Master reset pulse then idle long enough for presence to finish; returns timing in cycles.
    task automatic reset_pulse(input int low_cyc, output int rdly, output int pdly, output int plen);
        time t0, t1;
        t0 = $time;
        m_low = 1'b1;
        wait_cyc(low_cyc);
        t1 = $time;
        m_low = 1'b0;
        wait_cyc(1600);
        rdly = int'((t_rst - t0) / 100);
        pdly = int'((t_prise - t1) / 100);
        plen = int'((t_pfall - t_prise) / 100);
    endtask

    typedef struct {
        int         kind;     // 0 bus reset, 1 master write, 2 master read
        logic [7:0] dat;      // byte written / byte offered to tx
        int         exp_rst;  // rst_det pulses expected
        int         exp_rx;   // rx_vld pulses expected
        logic [7:0] exp_dat;  // expected rx_data (write) or read-back byte (read)
        logic       exp_rdy;  // tx_rdy at end
    } vec_t;

    vec_t       vecs[5];
    int         r0, x0, rd, pd, pl, k;
    logic [7:0] got;

    initial begin
        vecs[0] = '{0, 8'h00, 1, 0, 8'h00, 1'b1};
        vecs[1] = '{1, 8'hA5, 0, 1, 8'hA5, 1'b1};
        vecs[2] = '{2, 8'h3C, 0, 0, 8'h3C, 1'b1};
        vecs[3] = '{1, 8'h00, 0, 1, 8'h00, 1'b1};
        vecs[4] = '{2, 8'h81, 0, 0, 8'h81, 1'b1};

        arst_n  = 1'b0;
        m_low   = 1'b0;
        tx_vld  = 1'b0;
        tx_data = 8'h00;
        wait_cyc(3);
        chk("rst_pull_low", {31'd0, ow_pull_low}, 32'd0);
        chk("rst_rx_data",  {24'd0, rx_data},     32'd0);
        chk("rst_rx_vld",   {31'd0, rx_vld},      32'd0);
        chk("rst_tx_rdy",   {31'd0, tx_rdy},      32'd1);
        chk("rst_rst_det",  {31'd0, rst_det},     32'd0);
        arst_n = 1'b1;
        wait_cyc(5);

        for (int v = 0; v < 5; v++) begin
            r0 = n_rst;
            x0 = n_rx;
            case (vecs[v].kind)
                0: begin
                    reset_pulse(4800, rd, pd, pl);
                    chk_rng("rst_det_delay", rd, 4000, 4005);
                    chk_rng("presence_delay", pd, 300, 306);
                    chk("presence_len", pl, 1200);
                end
                1: write_byte(vecs[v].dat);
                default: begin
                    offer_tx(vecs[v].dat);
                    read_byte(got);
                    chk("read_byte", {24'd0, got}, {24'd0, vecs[v].exp_dat});
                end
            endcase
            chk("rst_det_cnt", n_rst - r0, vecs[v].exp_rst);
            chk("rx_vld_cnt", n_rx - x0, vecs[v].exp_rx);
            if (vecs[v].exp_rx != 0) chk("rx_data", {24'd0, last_rx}, {24'd0, vecs[v].exp_dat});
            chk("tx_rdy_end", {31'd0, tx_rdy}, {31'd0, vecs[v].exp_rdy});
        end

        // Bus reset after 4 write bits drops the partial byte; next byte still aligns.
        for (int i = 0; i < 4; i++) bus_low(60, 700);
        r0 = n_rst;
        x0 = n_rx;
        reset_pulse(4800, rd, pd, pl);
        chk("partial_no_rx", n_rx - x0, 0);
        chk("partial_rst_det", n_rst - r0, 1);
        chk("partial_presence_len", pl, 1200);
        write_byte(8'h81);
        chk("partial_rx_cnt", n_rx - x0, 1);
        chk("partial_rx_data", {24'd0, last_rx}, 32'h81);

        // A pending tx byte is discarded by a bus reset.
        offer_tx(8'h55);
        reset_pulse(4800, rd, pd, pl);
        chk("tx_discard_rdy", {31'd0, tx_rdy}, 32'd1);

        // 350us low is just a long write-0 slot: bit 0 = 0, then seven 1s -> 0xFE.
        r0 = n_rst;
        x0 = n_rx;
        bus_low(3500, 3600);
        chk("short_no_rst", n_rst - r0, 0);
        chk("short_mid_byte_rdy", {31'd0, tx_rdy}, 32'd0);
        for (int i = 0; i < 7; i++) bus_low(60, 700);
        chk("short_rx_cnt", n_rx - x0, 1);
        chk("short_rx_data", {24'd0, last_rx}, 32'hFE);
        chk("short_rdy_after", {31'd0, tx_rdy}, 32'd1);

        // Asynchronous reset during the presence pulse releases the bus at once.
        m_low = 1'b1;
        wait_cyc(4800);
        m_low = 1'b0;
        k = 0;
        while (ow_pull_low !== 1'b1 && k < 2000) begin
            wait_cyc(1);
            k++;
        end
        chk("arst_pd_seen", {31'd0, ow_pull_low}, 32'd1);
        wait_cyc(100);
        arst_n = 1'b0;
        #1;
        chk("arst_release", {31'd0, ow_pull_low}, 32'd0);
        wait_cyc(2);
        arst_n = 1'b1;
        wait_cyc(2);
        chk("arst_tx_rdy", {31'd0, tx_rdy}, 32'd1);
        chk("arst_rx_data", {24'd0, rx_data}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
